bam_prod_accumulator: RTL and testbench
=======================================

Name: bam_prod_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 unsigned broken-array approximate multiplier (h1/v11 truncation).
- Accepts one 16-bit approximate product per valid/ready handshake and sums FRAME_LEN products into one frame total.
- Presents the total on an output valid/ready handshake.
- Stores only the product bits the multiplier can drive (bits PROD_MSB..TRUNC_LSB), so the accumulator is narrow. Flags any activity on the structurally-zero bits.

Parameters:
- PROD_W, 16, input product width.
- TRUNC_LSB, 11, lowest product bit the multiplier drives; bits below are structurally zero.
- PROD_MSB, 14, highest product bit the multiplier drives; bits above are structurally zero.
- FRAME_LEN, 16, products per frame (>=2).
- ACC_W, 8, internal accumulator width; saturating.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- prod_i  in  PROD_W  approximate product.
- prod_valid_i  in  1  prod_i valid.
- prod_ready_o  out  1  stage can accept a product.
- clear_i  in  1  synchronous frame flush.
- acc_o  out  ACC_W+TRUNC_LSB  frame sum, in product units.
- acc_valid_o  out  1  acc_o valid.
- acc_ready_i  in  1  consumer accepts acc_o.
- sat_o  out  1  frame saturated; qualified by acc_valid_o.
- mask_err_o  out  1  sticky: a nonzero bit outside [PROD_MSB:TRUNC_LSB] was accepted.

Behaviour:
- Reset: one clock and one reset. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state=ACCUM, count=0, acc=0;
  - prod_ready_o=1, acc_valid_o=0, acc_o=0, sat_o=0, mask_err_o=0.
- Summand: s = prod_i[PROD_MSB:TRUNC_LSB], zero-extended to ACC_W.
- Accept event: prod_valid_i & prod_ready_o.
- FSM, two states:
  - ACCUM:
    - prod_ready_o=1.
    - On accept: acc <= sat(acc+s). If the true sum exceeds 2^ACC_W-1, acc <= all-ones and the frame saturation bit is set.
    - On accept with count==FRAME_LEN-1, the product is included in the total. The result registers are loaded: acc_o <= final_acc << TRUNC_LSB, sat_o <= final saturation bit. Then acc_valid_o <= 1, count <= 0, state <= HOLD.
    - Otherwise, on accept: count <= count+1.
  - HOLD:
    - prod_ready_o=0; acc_o and sat_o are stable.
    - On acc_ready_i: acc_valid_o <= 0, acc <= 0, saturation bit cleared, state <= ACCUM.
    - One bubble cycle: no same-cycle restart.
- Latency: acc_valid_o rises on the cycle after the FRAME_LEN-th accept.
- prod_ready_o is a registered state decode with no combinational path from any input.
- Saturation is sticky within a frame; later adds keep acc at all-ones.
- mask_err_o:
  - Set on any accept where prod_i has a 1 outside [PROD_MSB:TRUNC_LSB].
  - Cleared only by reset; clear_i does not clear it.
  - The offending bits are dropped from the sum.
- clear_i:
  - In ACCUM: acc, count and the saturation bit are zeroed. A product offered in the same cycle is discarded, and prod_ready_o stays 1.
  - In HOLD: ignored; a pending result is never lost.
- Reset mid-frame or mid-HOLD: all state is discarded and the reset values apply on the next cycle.
- count width: $clog2(FRAME_LEN).
- acc_o holds its last value when acc_valid_o=0; the consumer must not rely on it.

Decomposition:
- Shared package bam_pkg holds:
  - localparams BAM8_H1V11_LSB=11 and BAM8_H1V11_MSB=14;
  - a state enum type {ACCUM, HOLD};
  - function sat_add(acc, s) returning {sat, sum}.
- One sub-module is natural: bam_sat_adder, the ACC_W-bit saturating adder with a carry-out flag.

Test Plan:
- 16 accepts of prod_i=16'h7800 (s=15) with acc_ready_i=1 -> one cycle after the 16th accept: acc_valid_o=1, acc_o=19'h78000 (240<<11), sat_o=0. prod_ready_o is 0 for exactly one cycle.
- Same stimulus with ACC_W=6 -> acc_o=19'h1F800 (63<<11), sat_o=1. The next frame of 16x 16'h0800 -> acc_o=16<<11=19'h08000, sat_o=0.
- Frame completes with acc_ready_i=0 for 5 cycles while prod_valid_i=1 -> prod_ready_o=0 and acc_o stable throughout. Accepts resume on the cycle after acc_ready_i=1.
- prod_i=16'h0801 accepted -> mask_err_o=1 and s=1. mask_err_o persists across clear_i and later frames, until rst_n=0.
- 7 products of 16'h1000, then clear_i=1 together with prod_valid_i=1, then 16 products of 16'h1000 -> acc_o=32<<11=19'h10000. The product in the clear cycle is not counted.
- rst_n=0 for one cycle mid-frame (after 9 accepts) -> next cycle shows all reset values. A full following frame of 16'h0800 yields acc_o=19'h08000.

Source files
------------

// File: rtl/bam_pkg.sv
// Shared definitions for the broken-array multiplier (h1/v11) and its downstream stages.
package bam_pkg;

    localparam int unsigned BAM8_H1V11_LSB = 11;
    localparam int unsigned BAM8_H1V11_MSB = 14;
    localparam int unsigned SAT_ADD_W      = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Reference saturating add for any width up to SAT_ADD_W; returns {sat, sum}.
    function automatic logic [SAT_ADD_W:0] sat_add(
        input logic [SAT_ADD_W-1:0] acc,
        input logic [SAT_ADD_W-1:0] s,
        input int unsigned          w
    );
        logic [SAT_ADD_W:0] sum;
        logic [SAT_ADD_W:0] max;
        max = ((SAT_ADD_W+1)'(1) << w) - (SAT_ADD_W+1)'(1);
        sum = {1'b0, acc} + {1'b0, s};
        if (sum > max) begin
            return {1'b1, max[SAT_ADD_W-1:0]};
        end
        return {1'b0, sum[SAT_ADD_W-1:0]};
    endfunction

endpackage

// File: rtl/bam_prod_accumulator_sat_adder.sv
// ACC_W-bit saturating adder; carry_c flags that the true sum did not fit.
module bam_sat_adder #(
    parameter int unsigned ACC_W = 8
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_c,
    output logic             carry_c
);

    logic [ACC_W:0] raw;

    always_comb begin
        raw     = {1'b0, a_i} + {1'b0, b_i};
        carry_c = raw[ACC_W];
        sum_c   = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
    end

endmodule

// File: rtl/bam_prod_accumulator.sv
// Sums FRAME_LEN approximate products per frame into a narrow saturating accumulator
// and hands the total downstream over a valid/ready handshake.
module bam_prod_accumulator
    import bam_pkg::*;
#(
    parameter int unsigned PROD_W    = 16,
    parameter int unsigned TRUNC_LSB = BAM8_H1V11_LSB,
    parameter int unsigned PROD_MSB  = BAM8_H1V11_MSB,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned ACC_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PROD_W-1:0]          prod_i,
    input  logic                       prod_valid_i,
    output logic                       prod_ready_o,
    input  logic                       clear_i,
    output logic [ACC_W+TRUNC_LSB-1:0] acc_o,
    output logic                       acc_valid_o,
    input  logic                       acc_ready_i,
    output logic                       sat_o,
    output logic                       mask_err_o
);

    localparam int unsigned SUM_W = PROD_MSB - TRUNC_LSB + 1;
    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam int unsigned OUT_W = ACC_W + TRUNC_LSB;
    // Bits the multiplier can actually drive; anything else must be zero.
    localparam logic [PROD_W-1:0] IN_MASK =
        PROD_W'(((64'(1) << (PROD_MSB + 1)) - 64'(1)) ^ ((64'(1) << TRUNC_LSB) - 64'(1)));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               fsat_q, fsat_d;
    logic [OUT_W-1:0]   acc_o_q, acc_o_d;
    logic               sat_o_q, sat_o_d;
    logic               acc_valid_q, acc_valid_d;
    logic               prod_ready_q, prod_ready_d;
    logic               mask_err_q, mask_err_d;

    logic [SUM_W-1:0]   field;
    logic [ACC_W-1:0]   summand;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               accept;
    logic               last;

    assign field   = prod_i[PROD_MSB:TRUNC_LSB];
    assign summand = ACC_W'(field);
    assign accept  = prod_valid_i & prod_ready_q;
    assign last    = (count_q == CNT_W'(FRAME_LEN - 1));

    bam_sat_adder #(
        .ACC_W (ACC_W)
    ) u_sat_adder (
        .a_i     (acc_q),
        .b_i     (summand),
        .sum_c   (add_sum),
        .carry_c (add_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave ACCUM on the frame's final accept, leave HOLD on consumer ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && !clear_i && last) state_d = HOLD;
            HOLD:    if (acc_ready_i) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        count_d      = count_q;
        acc_d        = acc_q;
        fsat_d       = fsat_q;
        acc_o_d      = acc_o_q;
        sat_o_d      = sat_o_q;
        mask_err_d   = mask_err_q | (accept & (|(prod_i & ~IN_MASK)));
        acc_valid_d  = (state_d == HOLD);
        prod_ready_d = (state_d == ACCUM);
        case (state_q)
            ACCUM: begin
                if (clear_i) begin
                    count_d = '0;
                    acc_d   = '0;
                    fsat_d  = 1'b0;
                end else if (accept) begin
                    acc_d  = add_sum;
                    fsat_d = fsat_q | add_carry;
                    if (last) begin
                        acc_o_d = {add_sum, {TRUNC_LSB{1'b0}}};
                        sat_o_d = fsat_q | add_carry;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (acc_ready_i) begin
                    acc_d  = '0;
                    fsat_d = 1'b0;
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q      <= '0;
            acc_q        <= '0;
            fsat_q       <= 1'b0;
            acc_o_q      <= '0;
            sat_o_q      <= 1'b0;
            acc_valid_q  <= 1'b0;
            prod_ready_q <= 1'b1;
            mask_err_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            acc_q        <= acc_d;
            fsat_q       <= fsat_d;
            acc_o_q      <= acc_o_d;
            sat_o_q      <= sat_o_d;
            acc_valid_q  <= acc_valid_d;
            prod_ready_q <= prod_ready_d;
            mask_err_q   <= mask_err_d;
        end
    end

    assign prod_ready_o = prod_ready_q;
    assign acc_o        = acc_o_q;
    assign acc_valid_o  = acc_valid_q;
    assign sat_o        = sat_o_q;
    assign mask_err_o   = mask_err_q;

endmodule

// File: tb/tb_bam_prod_accumulator.sv
// Bench for bam_prod_accumulator: two instances (ACC_W=8 and ACC_W=6) on shared stimulus,
// checked every cycle against a frame-level model plus literal expectations.
module tb_bam_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] prod_i;
    logic        prod_valid_i;
    logic        clear_i;
    logic        acc_ready_i;

    logic        ready_a, valid_a, sat_a, merr_a;
    logic [18:0] acc_a;
    logic        ready_b, valid_b, sat_b, merr_b;
    logic [16:0] acc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bam_prod_accumulator u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .prod_ready_o (ready_a),
        .clear_i      (clear_i),
        .acc_o        (acc_a),
        .acc_valid_o  (valid_a),
        .acc_ready_i  (acc_ready_i),
        .sat_o        (sat_a),
        .mask_err_o   (merr_a)
    );

    bam_prod_accumulator #(.ACC_W(6)) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .prod_ready_o (ready_b),
        .clear_i      (clear_i),
        .acc_o        (acc_b),
        .acc_valid_o  (valid_b),
        .acc_ready_i  (acc_ready_i),
        .sat_o        (sat_b),
        .mask_err_o   (merr_b)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Frame-level model: true (unbounded) sum of 4-bit fields, clipped only when the frame ends.
    localparam int MW [2] = '{8, 6};
    bit m_on = 1'b0;
    bit m_hold [2];
    int m_n    [2];
    int m_sum  [2];
    int m_res  [2];
    bit m_rsat [2];
    bit m_mask [2];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_hold[i] = 0; m_n[i] = 0; m_sum[i] = 0;
                m_res[i]  = 0; m_rsat[i] = 0; m_mask[i] = 0;
            end
        end else if (m_on) begin
            for (int i = 0; i < 2; i++) begin
                int mx;
                mx = (1 << MW[i]) - 1;
                if (prod_valid_i && !m_hold[i] && ((prod_i & ~16'h7800) != 16'h0))
                    m_mask[i] = 1;
                if (m_hold[i]) begin
                    if (acc_ready_i) begin
                        m_hold[i] = 0;
                        m_sum[i]  = 0;
                    end
                end else if (clear_i) begin
                    m_n[i]   = 0;
                    m_sum[i] = 0;
                end else if (prod_valid_i) begin
                    m_sum[i] += int'((prod_i >> 11) & 16'hF);
                    if (m_n[i] == 15) begin
                        m_res[i]  = (m_sum[i] > mx) ? mx : m_sum[i];
                        m_rsat[i] = (m_sum[i] > mx);
                        m_hold[i] = 1;
                        m_n[i]    = 0;
                    end else begin
                        m_n[i]++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_on) begin
            chk("a_ready", 32'(ready_a), 32'(!m_hold[0]));
            chk("a_valid", 32'(valid_a), 32'(m_hold[0]));
            chk("a_mask",  32'(merr_a),  32'(m_mask[0]));
            chk("b_ready", 32'(ready_b), 32'(!m_hold[1]));
            chk("b_valid", 32'(valid_b), 32'(m_hold[1]));
            chk("b_mask",  32'(merr_b),  32'(m_mask[1]));
            if (m_hold[0]) begin
                chk("a_acc", 32'(acc_a), 32'(m_res[0] << 11));
                chk("a_sat", 32'(sat_a), 32'(m_rsat[0]));
            end
            if (m_hold[1]) begin
                chk("b_acc", 32'(acc_b), 32'(m_res[1] << 11));
                chk("b_sat", 32'(sat_b), 32'(m_rsat[1]));
            end
        end
    end

    task automatic cyc(input logic v, input logic [15:0] p, input logic c, input logic r);
        prod_valid_i = v;
        prod_i       = p;
        clear_i      = c;
        acc_ready_i  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] p, input int n, input logic r);
        for (int k = 0; k < n; k++) cyc(1'b1, p, 1'b0, r);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_ready"}, 32'(ready_a), 32'd1);
        chk({tag, "_valid"}, 32'(valid_a), 32'd0);
        chk({tag, "_acc"},   32'(acc_a),   32'd0);
        chk({tag, "_sat"},   32'(sat_a),   32'd0);
        chk({tag, "_mask"},  32'(merr_a),  32'd0);
        chk({tag, "_acc_b"}, 32'(acc_b),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; prod_valid_i = 1'b0; prod_i = '0; clear_i = 1'b0; acc_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst0");
        rst_n = 1'b1;

        // 16 x s=15: 240 fits in 8 bits, saturates at 63 in 6 bits
        frame(16'h7800, 16, 1'b1);
        chk("f1_valid", 32'(valid_a), 32'd1);
        chk("f1_ready", 32'(ready_a), 32'd0);
        chk("f1_acc_a", 32'(acc_a),   32'h78000);
        chk("f1_sat_a", 32'(sat_a),   32'd0);
        chk("f1_acc_b", 32'(acc_b),   32'h1F800);
        chk("f1_sat_b", 32'(sat_b),   32'd1);
        chk("model_res_a", 32'(m_res[0]), 32'd240);
        chk("model_res_b", 32'(m_res[1]), 32'd63);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("f1_bubble_ready", 32'(ready_a), 32'd1);
        chk("f1_bubble_valid", 32'(valid_a), 32'd0);

        // Saturation does not leak into the next frame
        frame(16'h0800, 16, 1'b1);
        chk("f2_acc_b", 32'(acc_b), 32'h08000);
        chk("f2_sat_b", 32'(sat_b), 32'd0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Back-pressure: result held for 5 cycles while a producer keeps offering
        frame(16'h0800, 16, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 16'h0800, 1'b0, 1'b0);
            chk("hold_ready", 32'(ready_a), 32'd0);
            chk("hold_acc",   32'(acc_a),   32'h08000);
        end
        cyc(1'b1, 16'h0800, 1'b0, 1'b1);
        chk("release_ready", 32'(ready_a), 32'd1);
        frame(16'h0800, 16, 1'b1);
        chk("f3_acc_a", 32'(acc_a), 32'h08000);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Stray LSB: flagged, dropped from the sum
        cyc(1'b1, 16'h0801, 1'b0, 1'b1);
        chk("mask_set", 32'(merr_a), 32'd1);
        frame(16'h0800, 15, 1'b1);
        chk("mask_acc", 32'(acc_a), 32'h08000);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Clear mid-frame discards the coincident product
        frame(16'h1000, 7, 1'b1);
        cyc(1'b1, 16'h1000, 1'b1, 1'b1);
        chk("clr_ready", 32'(ready_a), 32'd1);
        chk("clr_mask",  32'(merr_a),  32'd1);
        frame(16'h1000, 16, 1'b1);
        chk("clr_acc_a", 32'(acc_a), 32'h10000);
        chk("clr_acc_b", 32'(acc_b), 32'h10000);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Reset mid-frame
        frame(16'h0800, 9, 1'b1);
        rst_n = 1'b0;
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk_reset("rst1");
        rst_n = 1'b1;
        frame(16'h0800, 16, 1'b1);
        chk("post_rst_acc", 32'(acc_a), 32'h08000);
        chk("post_rst_valid", 32'(valid_a), 32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
